axis_sync_fifo: RTL
===================

# axis_sync_fifo

Parametrised single-clock AXI4-Stream FIFO; successor to the fixed 16x8 data FIFO in the UART datapath. Adds configurable width/depth, first-word-fall-through output with proper AXIS hold semantics, full usable depth, synchronous flush, and optional level reporting. Sits between the UART RX deserialiser and the host-side consumer, and between the host producer and the UART TX serialiser.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 16, capacity in words; power of two, >=2
- AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when level <= this value (0..DEPTH-1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  synchronous clear of contents, active-high
- s_axis_tdata  in  WIDTH  write data
- s_axis_tvalid  in  1  write data valid
- s_axis_tready  out  1  FIFO can accept (= not full)
- m_axis_tdata  out  WIDTH  head-of-FIFO data
- m_axis_tvalid  out  1  head-of-FIFO valid (= not empty)
- m_axis_tready  in  1  consumer accepts head word
- fill_level  out  $clog2(DEPTH)+1  words held (only with AXIS_FIFO_LEVEL_EN)
- almost_full  out  1  level >= AFULL_THRESH (only with AXIS_FIFO_LEVEL_EN)
- almost_empty  out  1  level <= AFULL/AEMPTY rule above (only with AXIS_FIFO_LEVEL_EN)

## Operation
- Write handshake: wr = s_axis_tvalid & s_axis_tready; read handshake: rd = m_axis_tvalid & m_axis_tready.
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; low bits address memory, MSB is wrap bit. Empty when pointers equal; full when low bits equal and MSBs differ. All DEPTH entries usable.
- FWFT: m_axis_tdata is a combinational read of mem[rd_ptr low bits]; valid whenever not empty. tdata/tvalid stay stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
- s_axis_tready = !full, independent of s_axis_tvalid; m_axis_tvalid = !empty, independent of m_axis_tready (no combinational valid->ready paths).
- Full: writes refused even if a read occurs in the same cycle (no pass-through); tready rises the cycle after the read.
- Empty: no bypass; a word written in cycle N is visible at the output from cycle N+1.
- Simultaneous rd and wr when neither full nor empty: both pointers advance, level unchanged.
- Pointer arithmetic wraps modulo 2*DEPTH; no saturation logic needed.
- flush: pointers to 0, level 0; any handshake in the flush cycle is discarded. Memory contents not cleared.
- rst_n low: same as flush; memory not reset.

## Timing
- Reset/flush values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=don't-care (memory content), fill_level=0, almost_full=0 (AFULL_THRESH>=1), almost_empty=1.
- Write-to-read latency: 1 cycle (edge that captures write makes tvalid high).
- Read-to-ready latency when full: 1 cycle.
- fill_level, almost_full, almost_empty are registered, updated on the same edge as pointers; they equal wr_ptr-rd_ptr at all times.
- Reset asserted mid-transfer takes effect at the next edge; in-flight words are lost, no partial state.

## Configuration
- AXIS_FIFO_LEVEL_EN defined: fill_level, almost_full, almost_empty ports and the level register exist; level increments on wr&!rd, decrements on rd&!wr.
- Not defined: those three ports and the counter are absent; full/empty derive from pointers only; AFULL_THRESH/AEMPTY_THRESH ignored.

## Structure
- Package axis_fifo_pkg: ptr-width constant function (clog2+1), threshold legality checks, default parameter constants.
- One sub-module: axis_fifo_ram — DEPTH x WIDTH memory, synchronous write port, asynchronous read port, no reset.
- Top holds pointers, flags, level counter, handshake logic.

## Test plan
(WIDTH=8, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2, macro defined)
- Reset then write 0xA5 with m_axis_tready=0 -> next cycle m_axis_tvalid=1, tdata=0xA5, fill_level=1; held stable 10 cycles with tready low.
- Write 0x00..0x0F back-to-back, tready=0 -> s_axis_tready=0 after 16th write, fill_level=16, almost_full from level 14; 17th word 0x10 not accepted.
- From full, assert tready one cycle with tvalid held on input -> read 0x00, no write that cycle, s_axis_tready=1 next cycle, then 0x10 accepted; output order 0x01..0x10.
- Continuous simultaneous read/write for 40 cycles at level 5 -> fill_level stays 5, data in order, pointer wrap twice without error.
- Write 8 words then assert flush together with tvalid/tready -> next cycle m_axis_tvalid=0, fill_level=0, almost_empty=1, no word consumed or added.
- Drop rst_n at level 9 mid-stream -> next edge s_axis_tready=1, m_axis_tvalid=0, fill_level=0; rebuild without macro -> level ports absent, same data behaviour.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared constants and parameter-legality helpers for the AXI4-Stream sync FIFO.
package axis_fifo_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_AEMPTY_THRESH = 2;

  // One extra bit beyond the address gives the wrap flag that separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_ok(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit aempty_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents never reset.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO using every entry of its storage.
// Define AXIS_FIFO_LEVEL_EN to add the registered fill_level / almost_full / almost_empty outputs.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [WIDTH-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
`ifdef AXIS_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] fill_level,
  output logic                       almost_full,
  output logic                       almost_empty
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (!(WIDTH >= 1 && depth_ok(DEPTH) && afull_ok(AFULL_THRESH, DEPTH) &&
        aempty_ok(AEMPTY_THRESH, DEPTH))) begin : g_bad_params
    $error("axis_sync_fifo: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          w_full, w_empty, w_wr, w_rd, w_clear;

  assign w_clear = !rst_n || flush;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Ready/valid come from state only, so a read never frees a slot in its own cycle.
  assign s_axis_tready = !w_full;
  assign m_axis_tvalid = !w_empty;
  assign w_wr          = s_axis_tvalid && !w_full;
  assign w_rd          = m_axis_tready && !w_empty;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  axis_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr && !w_clear),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (s_axis_tdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (m_axis_tdata)
  );

`ifdef AXIS_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0] r_level, w_level_nxt;
  logic          r_afull, r_aempty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + PW'(1);
      2'b01:   w_level_nxt = r_level - PW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags are registered from the next level so they track fill_level on the same edge.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_level  <= w_level_nxt;
      r_afull  <= (w_level_nxt >= AF_T);
      r_aempty <= (w_level_nxt <= AE_T);
    end
  end

  assign fill_level   = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
`endif

endmodule
